spike_rate_encoder: RTL and testbench

SPIKE_RATE_ENCODER -- requirements
Module: spike_rate_encoder

---
 rtl/spike_rate_encoder.sv | 53 +++++
 tb/tb_spike_rate_encoder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: rate-codes a latched pixel intensity into a spike train by comparing it against an LFSR each timestep
module spike_rate_encoder #(
  parameter int          DATA_WIDTH = 8,
  parameter int          NUM_STEPS  = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          intensity,
  input  logic                           tick,
  output logic                           spike_out,
  output logic [$clog2(NUM_STEPS+1)-1:0] spike_count,
  output logic                           done
);
  localparam int CW = $clog2(NUM_STEPS + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                state, state_n;
  logic [15:0]           lfsr;
  logic [DATA_WIDTH-1:0] lat;
  logic [CW-1:0]         step;
  logic                  accept, run_tick, last, spike;
  assign in_ready = state == IDLE;
  assign accept   = in_valid && in_ready;
  assign run_tick = tick && state == RUN;
  assign last     = step == CW'(NUM_STEPS - 1);
  assign spike    = &lat || lfsr[15 -: DATA_WIDTH] < lat;
  always_comb state_n = accept ? RUN : (run_tick && last) ? IDLE : state;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr        <= LFSR_SEED;
      lat         <= '0;
      step        <= '0;
      spike_count <= '0;
      spike_out   <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (tick) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      spike_out <= run_tick && spike;
      done      <= run_tick && last;
      if (accept) begin
        lat         <= intensity;
        step        <= '0;
        spike_count <= '0;
      end else if (run_tick) begin
        step <= step + CW'(1);
        if (spike && spike_count != CW'(NUM_STEPS)) spike_count <= spike_count + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb_spike_rate_encoder: directed and randomized checks of spike_rate_encoder against a timestep-level reference model
module tb_spike_rate_encoder;
  localparam logic [15:0] SEED = 16'hACE1;
  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, tick = 1'b0;
  logic [7:0] intensity = 8'd0;
  logic       in_ready, spike_out, done;
  logic [4:0] spike_count;
  int         checks = 0, failures = 0, spikes_seen = 0, dones_seen = 0;
  logic [15:0] m_lfsr;
  bit         m_run, exp_spike, exp_done;
  int         m_lat, m_steps, m_cnt;
  always #5 clk = ~clk;
  spike_rate_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .intensity(intensity),
    .tick(tick), .spike_out(spike_out), .spike_count(spike_count), .done(done)
  );
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    int rnd;
    exp_spike = 1'b0;
    exp_done  = 1'b0;
    if (rst) begin
      m_lfsr = SEED; m_run = 1'b0; m_lat = 0; m_steps = 0; m_cnt = 0;
    end else begin
      rnd = int'(m_lfsr) / 256;
      if (tick && m_run) begin
        exp_spike = (m_lat == 255) || (rnd < m_lat);
        if (exp_spike && m_cnt < 16) m_cnt++;
        m_steps++;
        if (m_steps == 16) begin
          exp_done = 1'b1;
          m_run = 1'b0;
        end
      end else if (in_valid && !m_run) begin
        m_run = 1'b1; m_lat = int'(intensity); m_steps = 0; m_cnt = 0;
      end
      if (tick) m_lfsr = lfsr_next(m_lfsr);
    end
    @(posedge clk);
    #1;
    chk("spike_out", spike_out, exp_spike);
    chk("done", done, exp_done);
    chk("in_ready", in_ready, !m_run);
    chk("spike_count", spike_count, m_cnt);
    spikes_seen += int'(spike_out);
    dones_seen  += int'(done);
  endtask
  task automatic accept(input int val, input bit with_tick);
    in_valid = 1'b1; intensity = 8'(val); tick = with_tick;
    cycle();
    in_valid = 1'b0; tick = 1'b0;
    spikes_seen = 0; dones_seen = 0;
  endtask
  task automatic ticks(input int n, input int gap);
    int g;
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      g = gap == 0 ? int'($urandom_range(1, 3)) : gap;
      for (int j = 1; j < g; j++) cycle();
    end
  endtask
  initial begin
    rst = 1'b1;
    cycle();
    cycle();
    chk("reset_lfsr", dut.lfsr, SEED);
    rst = 1'b0;
    cycle();
    accept(0, 1'b0);
    ticks(16, 0);
    chk("zero_spikes", spikes_seen, 0);
    chk("zero_count", spike_count, 0);
    chk("zero_done_pulses", dones_seen, 1);
    accept(255, 1'b0);
    ticks(16, 3);
    chk("full_spikes", spikes_seen, 16);
    chk("full_count", spike_count, 16);
    chk("full_done_pulses", dones_seen, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    accept(128, 1'b0);
    ticks(16, 0);
    chk("half_spikes_vs_model", spikes_seen, m_cnt);
    chk("half_lfsr", dut.lfsr, m_lfsr);
    accept(200, 1'b0);
    in_valid = 1'b1; intensity = 8'd7;
    ticks(16, 1);
    chk("busy_done_pulses", dones_seen, 1);
    cycle();
    chk("late_accept_lat", dut.lat, 7);
    in_valid = 1'b0;
    ticks(16, 2);
    accept(int'($urandom_range(1, 254)), 1'b0);
    ticks(5, 1);
    rst = 1'b1; tick = 1'b1; in_valid = 1'b1;
    cycle();
    rst = 1'b0; tick = 1'b0; in_valid = 1'b0;
    chk("abort_ready", in_ready, 1);
    chk("abort_count", spike_count, 0);
    chk("abort_lfsr", dut.lfsr, SEED);
    chk("abort_done", done, 0);
    accept(int'($urandom_range(0, 255)), 1'b1);
    chk("coincident_tick_lfsr", dut.lfsr, lfsr_next(SEED));
    ticks(15, 1);
    chk("coincident_no_early_done", dones_seen, 0);
    ticks(1, 1);
    chk("coincident_done", dones_seen, 1);
    for (int s = 0; s < 8; s++) begin
      accept(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 300 && m_run; c++) begin
        tick = $urandom_range(0, 2) == 0;
        in_valid = 1'($urandom_range(0, 1));
        intensity = 8'($urandom);
        cycle();
      end
      tick = 1'b0; in_valid = 1'b0;
      chk("rand_finished", m_run, 0);
      chk("rand_lfsr", dut.lfsr, m_lfsr);
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
